// File: rtl/n64_vdemux.sv
// -----------------------------------------------------------------------------
// n64_vdemux
//
// Turns the time-multiplexed N64 video bus into one parallel pixel word. Each
// pixel arrives as four VCLK cycles: a sync phase (nDSYNC low, sync nibble on
// D_i[3:0]), then R, G and B. The block also counts lines and fields from the
// recovered sync bits and reports PAL/NTSC and interlaced/progressive.
//
// Ports
//   VCLK           video clock, the only clock
//   VRST           synchronous active-high reset
//   nDSYNC         data-sync strobe, low during the sync phase
//   D_i            multiplexed video bus
//   vdata_valid_o  one-cycle pulse per assembled pixel
//   vdata_o        {nVSYNC,nCLAMP,nHSYNC,nCSYNC,R,G,B}, held between pulses
//   vinfo_o        {palmode,interlaced}, updated only on a vsync fall
//   sync_err_o     one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module n64_vdemux #(
  parameter int color_width_i = 7
) (
  input  logic                         VCLK,
  input  logic                         VRST,
  input  logic                         nDSYNC,
  input  logic [color_width_i-1:0]     D_i,
  output logic                         vdata_valid_o,
  output logic [3*color_width_i+3:0]   vdata_o,
  output logic [1:0]                   vinfo_o,
  output logic                         sync_err_o
);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    CAP_R,
    CAP_G,
    CAP_B
  } state_t;

  localparam logic [9:0] LINE_MAX = 10'd1023;
  localparam logic [9:0] PAL_MIN  = 10'd288;

  state_t                    state_q;
  logic [3:0]                sync_hold_q;
  logic [color_width_i-1:0]  r_q;
  logic [color_width_i-1:0]  g_q;
  logic [color_width_i-1:0]  b_q;
  logic                      pix_rdy_q;    // B captured last edge, publish now
  logic                      miss_seen_q;  // current missing-sync run already reported
  logic                      post_rst_q;   // first cycle after reset
  logic [3:0]                prev_sync_q;  // sync nibble of the previous output pixel
  logic [9:0]                line_cnt_q;
  logic [9:0]                field_lines_q;
  logic [1:0]                field_cnt_q;
  logic                      palmode_q;
  logic                      interlaced_q;
  logic [3*color_width_i+3:0] vdata_q;
  logic                      valid_q;
  logic                      err_q;

  logic                      vfall;
  logic                      hfall;
  logic [9:0]                line_cnt_d;
  logic [1:0]                field_cnt_d;

  // Edges are judged between consecutive output pixels, using the nibble that
  // is about to be published against the one published before it.
  always_comb begin
    vfall       = prev_sync_q[3] & ~sync_hold_q[3];
    hfall       = prev_sync_q[1] & ~sync_hold_q[1];
    line_cnt_d  = (line_cnt_q == LINE_MAX) ? line_cnt_q : line_cnt_q + 10'd1;
    field_cnt_d = (field_cnt_q == 2'd2) ? field_cnt_q : field_cnt_q + 2'd1;
  end

  always_ff @(posedge VCLK) begin
    if (VRST) begin
      state_q       <= WAIT_SYNC;
      sync_hold_q   <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      pix_rdy_q     <= 1'b0;
      miss_seen_q   <= 1'b0;
      post_rst_q    <= 1'b1;
      prev_sync_q   <= '0;
      line_cnt_q    <= '0;
      field_lines_q <= '0;
      field_cnt_q   <= '0;
      palmode_q     <= 1'b0;
      interlaced_q  <= 1'b0;
      vdata_q       <= '0;
      valid_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      pix_rdy_q  <= 1'b0;
      post_rst_q <= 1'b0;

      if (!nDSYNC) begin
        // A sync phase always restarts a pixel; arriving mid-pixel drops it.
        sync_hold_q <= D_i[3:0];
        state_q     <= CAP_R;
        miss_seen_q <= 1'b0;
        if (state_q == CAP_G || state_q == CAP_B) begin
          err_q <= 1'b1;
        end
      end else begin
        case (state_q)
          WAIT_SYNC: begin
            // Report a missing sync once per run; the cycle straight after
            // reset is not a framing error.
            if (!post_rst_q) begin
              err_q       <= ~miss_seen_q;
              miss_seen_q <= 1'b1;
            end
          end
          CAP_R: begin
            r_q     <= D_i;
            state_q <= CAP_G;
          end
          CAP_G: begin
            g_q     <= D_i;
            state_q <= CAP_B;
          end
          CAP_B: begin
            b_q       <= D_i;
            pix_rdy_q <= 1'b1;
            state_q   <= WAIT_SYNC;
          end
        endcase
      end

      if (pix_rdy_q) begin
        vdata_q     <= {sync_hold_q, r_q, g_q, b_q};
        valid_q     <= 1'b1;
        prev_sync_q <= sync_hold_q;
        if (vfall) begin
          // vsync wins over a coincident hsync fall; the line count restarts at 0.
          // The first field is partial, so palmode waits for one completed
          // field and interlaced waits for two.
          if (field_cnt_q != 2'd0) begin
            palmode_q <= (line_cnt_q >= PAL_MIN);
          end
          if (field_cnt_q == 2'd2) begin
            interlaced_q <= (line_cnt_q != field_lines_q);
          end
          field_lines_q <= line_cnt_q;
          line_cnt_q    <= '0;
          field_cnt_q   <= field_cnt_d;
        end else if (hfall) begin
          line_cnt_q <= line_cnt_d;
        end
      end
    end
  end

  assign vdata_valid_o = valid_q;
  assign vdata_o       = vdata_q;
  assign vinfo_o       = {palmode_q, interlaced_q};
  assign sync_err_o    = err_q;

endmodule

// File: tb/tb_n64_vdemux.sv
// -----------------------------------------------------------------------------
// tb_n64_vdemux
//
// Scoreboard bench for n64_vdemux. The driver pushes the expected pixel word and
// vinfo for every complete pixel it sends (and counts expected sync errors);
// a monitor on the falling edge pops and compares whenever the DUT pulses
// vdata_valid_o or sync_err_o. Field bookkeeping is kept as a small model of
// line/field counts derived from the sync nibbles the driver chooses.
// -----------------------------------------------------------------------------
module tb_n64_vdemux;
  localparam int W  = 7;
  localparam int DW = 3*W+4;

  logic          VCLK = 1'b0;
  logic          VRST = 1'b1;
  logic          nDSYNC = 1'b1;
  logic [W-1:0]  D_i = '0;
  logic          vdata_valid_o;
  logic [DW-1:0] vdata_o;
  logic [1:0]    vinfo_o;
  logic          sync_err_o;

  n64_vdemux #(.color_width_i(W)) dut (
    .VCLK          (VCLK),
    .VRST          (VRST),
    .nDSYNC        (nDSYNC),
    .D_i           (D_i),
    .vdata_valid_o (vdata_valid_o),
    .vdata_o       (vdata_o),
    .vinfo_o       (vinfo_o),
    .sync_err_o    (sync_err_o)
  );

  always #5 VCLK = ~VCLK;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    info;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   err_pending = 0;
  int   n_pass = 0;
  int   n_total = 0;

  // Reference bookkeeping: lines seen in the current field, length of the
  // last completed field, fields seen (capped at 2), and reported flags.
  int         m_lines;
  int         m_last_field;
  int         m_fields;
  bit         m_pal;
  bit         m_il;
  logic [3:0] m_last_sync;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic model_reset();
    m_lines = 0; m_last_field = 0; m_fields = 0;
    m_pal = 1'b0; m_il = 1'b0; m_last_sync = 4'h0;
  endtask

  // Apply the field rules to one published pixel's sync nibble.
  task automatic model_pixel(input logic [3:0] s);
    bit vf, hf;
    vf = m_last_sync[3] && !s[3];
    hf = m_last_sync[1] && !s[1];
    if (vf) begin
      if (m_fields >= 1) m_pal = (m_lines >= 288);
      if (m_fields == 2) m_il  = (m_lines != m_last_field);
      m_last_field = m_lines;
      m_lines      = 0;
      if (m_fields < 2) m_fields++;
    end else if (hf) begin
      if (m_lines < 1023) m_lines++;
    end
    m_last_sync = s;
  endtask

  task automatic exp_push(input logic [3:0] s, input logic [W-1:0] r, g, b);
    exp_t e;
    model_pixel(s);
    e.data = {s, r, g, b};
    e.info = {m_pal, m_il};
    exp_q.push_back(e);
  endtask

  task automatic tick(input bit ds, input logic [W-1:0] d);
    nDSYNC = ds;
    D_i    = d;
    @(posedge VCLK);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  function automatic logic [W-1:0] sync_word(input logic [3:0] s);
    logic [W-1:0] d;
    d      = rnd();
    d[3:0] = s;
    return d;
  endfunction

  // Sync nibble with chosen nVSYNC/nHSYNC and random nCLAMP/nCSYNC.
  function automatic logic [3:0] mk(input bit nv, input bit nh);
    logic [1:0] x;
    x = 2'($urandom);
    return {nv, x[1], nh, x[0]};
  endfunction

  task automatic rpix(input logic [3:0] s);
    logic [W-1:0] r, g, b;
    r = rnd(); g = rnd(); b = rnd();
    exp_push(s, r, g, b);
    tick(1'b0, sync_word(s));
    tick(1'b1, r);
    tick(1'b1, g);
    tick(1'b1, b);
  endtask

  task automatic field(input int nlines, input bit coincide);
    rpix(mk(1'b0, !coincide));
    rpix(mk(1'b1, 1'b1));
    for (int i = 0; i < nlines; i++) begin
      rpix(mk(1'b1, 1'b0));
      rpix(mk(1'b1, 1'b1));
    end
    $display("field: vsync%s then %0d lines, model vinfo=%b", coincide ? "+hsync" : "",
             nlines, {m_pal, m_il});
  endtask

  // Monitor: compare every valid pulse and every error pulse with the scoreboard.
  initial begin
    forever begin
      @(negedge VCLK);
      if (vdata_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL valid_unexpected: got valid with vdata 0x%0h, expected no valid", vdata_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("vdata", 32'(vdata_o), 32'(mon_e.data));
          chk("vinfo", 32'(vinfo_o), 32'(mon_e.info));
        end
      end
      if (sync_err_o === 1'b1) begin
        n_total++;
        if (err_pending > 0) begin
          err_pending--;
          n_pass++;
        end else begin
          $display("FAIL sync_err_unexpected: got sync_err=1, expected 0");
        end
      end
    end
  end

  initial begin
    logic [W-1:0] r, g, b;
    logic [3:0]   s;
    model_reset();

    // Reset state
    VRST = 1'b1;
    repeat (3) @(posedge VCLK);
    #1;
    chk("rst_valid", 32'(vdata_valid_o), 0);
    chk("rst_vdata", 32'(vdata_o), 0);
    chk("rst_vinfo", 32'(vinfo_o), 0);
    chk("rst_err", 32'(sync_err_o), 0);
    VRST = 1'b0;
    $display("reset: outputs checked");

    // Directed pixel, latency and hold
    exp_push(4'hF, 7'h11, 7'h22, 7'h33);
    tick(1'b0, 7'h0F);
    tick(1'b1, 7'h11);
    tick(1'b1, 7'h22);
    tick(1'b1, 7'h33);
    chk("valid_at_b_edge", 32'(vdata_valid_o), 0);
    r = rnd(); g = rnd(); b = rnd();
    exp_push(4'hF, r, g, b);
    tick(1'b0, 7'h0F);
    chk("valid_b_plus1", 32'(vdata_valid_o), 1);
    chk("vdata_directed", 32'(vdata_o), 32'({4'hF, 7'h11, 7'h22, 7'h33}));
    tick(1'b1, r);
    chk("valid_one_cycle", 32'(vdata_valid_o), 0);
    chk("vdata_hold", 32'(vdata_o), 32'({4'hF, 7'h11, 7'h22, 7'h33}));
    tick(1'b1, g);
    tick(1'b1, b);
    $display("directed pixel 0x0F/11/22/33 sent");
    repeat (20) rpix(mk(1'b1, 1'b1));
    $display("random pixels: 20 sent");

    // Early sync in CAP_G (k=0) and CAP_B (k=1)
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, sync_word(mk(1'b1, 1'b1)));
      tick(1'b1, rnd());
      if (k == 1) tick(1'b1, rnd());
      err_pending++;
      s = mk(1'b1, 1'b1);
      r = rnd(); g = rnd(); b = rnd();
      exp_push(s, r, g, b);
      tick(1'b0, sync_word(s));
      tick(1'b1, r);
      tick(1'b1, g);
      tick(1'b1, b);
      rpix(mk(1'b1, 1'b1));
      chk("early_sync_err", 32'(err_pending), 0);
      $display("early sync in %s: pixel dropped, next pixel queued", k == 0 ? "CAP_G" : "CAP_B");
    end

    // Missing sync: six idle cycles after B give one error and no pixel
    rpix(mk(1'b1, 1'b1));
    err_pending++;
    repeat (6) tick(1'b1, rnd());
    chk("missing_sync_err", 32'(err_pending), 0);
    chk("missing_sync_noval", 32'(exp_q.size()), 0);
    $display("missing sync: 6 idle cycles");
    rpix(mk(1'b1, 1'b1));

    // NTSC fields
    repeat (3) field(262, 1'b0);
    chk("ntsc_vinfo", 32'(vinfo_o), 32'({m_pal, m_il}));
    chk("ntsc_vinfo_00", 32'(vinfo_o), 0);

    // PAL alternating fields
    field(312, 1'b0);
    field(313, 1'b0);
    field(312, 1'b0);
    chk("pal_vinfo", 32'(vinfo_o), 32'({m_pal, m_il}));
    chk("pal_vinfo_11", 32'(vinfo_o), 3);

    // Coincident vsync/hsync: following field must count the same lines
    field(262, 1'b0);
    field(262, 1'b0);
    field(262, 1'b1);
    field(262, 1'b0);
    chk("coincide_vinfo_00", 32'(vinfo_o), 0);

    // Put vinfo at 11 so the reset clear is visible
    field(312, 1'b0);
    field(0, 1'b0);
    chk("pre_rst_vinfo_11", 32'(vinfo_o), 3);

    // Reset between G and B
    tick(1'b0, sync_word(mk(1'b1, 1'b1)));
    tick(1'b1, rnd());
    tick(1'b1, rnd());
    VRST = 1'b1;
    tick(1'b1, rnd());
    chk("midrst_valid", 32'(vdata_valid_o), 0);
    chk("midrst_vdata", 32'(vdata_o), 0);
    chk("midrst_vinfo", 32'(vinfo_o), 0);
    chk("midrst_err", 32'(sync_err_o), 0);
    VRST = 1'b0;
    model_reset();
    tick(1'b1, rnd());
    chk("post_rst_err", 32'(sync_err_o), 0);
    chk("post_rst_valid", 32'(vdata_valid_o), 0);
    $display("reset between G and B: outputs cleared");
    repeat (5) rpix(mk(1'b1, 1'b1));

    // Drain with sync phases (no missing-sync errors)
    tick(1'b0, 7'h0F);
    tick(1'b0, 7'h0F);
    chk("end_exp_empty", 32'(exp_q.size()), 0);
    chk("end_err_pending", 32'(err_pending), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/n64_vdemux.md
N64_VDEMUX -- requirements
Module: n64_vdemux

Interface
REQ-001 The block SHALL take parameter color_width_i, default 7, giving the bits per colour component.
REQ-002 The block SHALL have port VCLK, input, 1 bit: the video clock; it is the only clock.
REQ-003 The block SHALL have port VRST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port nDSYNC, input, 1 bit: N64 data-sync strobe, low during the sync phase.
REQ-005 The block SHALL have port D_i, input, color_width_i bits: the multiplexed N64 video bus.
REQ-006 The block SHALL have port vdata_valid_o, output, 1 bit: one-cycle pulse per assembled pixel.
REQ-007 The block SHALL have port vdata_o, output, 3*color_width_i+4 bits, packed as {nVSYNC,nCLAMP,nHSYNC,nCSYNC,R,G,B}, MSB first.
REQ-008 The block SHALL have port vinfo_o, output, 2 bits: {palmode,interlaced}.
REQ-009 The block SHALL have port sync_err_o, output, 1 bit: one-cycle pulse on a framing violation.

Function
REQ-010 The demux FSM SHALL have four states: WAIT_SYNC, CAP_R, CAP_G, CAP_B.
REQ-011 In any state, nDSYNC=0 SHALL latch D_i[3:0] into the sync-hold register and move the FSM to CAP_R.
REQ-012 CAP_R, CAP_G and CAP_B with nDSYNC=1 SHALL latch D_i into the R, G and B registers respectively, and advance R->G->B->WAIT_SYNC.
REQ-013 nDSYNC=0 seen in CAP_G or CAP_B (early sync) SHALL discard the partial pixel and pulse sync_err_o the next cycle; the sync nibble is still captured per REQ-011.
REQ-014 nDSYNC=1 seen in WAIT_SYNC (missing sync) SHALL keep the FSM in WAIT_SYNC and pulse sync_err_o the next cycle, at most once per missing-sync run.
REQ-015 The cycle after B is captured, vdata_o SHALL be registered as {sync_hold,R,G,B} and vdata_valid_o SHALL be 1 for exactly one cycle.
REQ-016 vdata_o SHALL hold its value between valid pulses.
REQ-017 Latency from the B sample edge to vdata_valid_o=1 SHALL be exactly 1 VCLK.
REQ-018 A 10-bit line counter SHALL increment, saturating at 1023, on a falling nHSYNC between consecutive output pixels.
REQ-019 On a falling nVSYNC between consecutive output pixels, the block SHALL set field_lines to line_cnt, clear line_cnt, and increment a 2-bit field counter that saturates at 2.
REQ-020 When falling nVSYNC and falling nHSYNC occur on the same pixel, vsync SHALL win and line_cnt SHALL become 0.
REQ-021 palmode SHALL be updated at each nVSYNC fall to (line_cnt >= 288), and only once the field counter is >=1.
REQ-022 interlaced SHALL be updated at each nVSYNC fall to (line_cnt != previous field_lines), and only once the field counter is 2.
REQ-023 vinfo_o SHALL change only at a vsync fall; it holds its value at all other times.

Reset
REQ-024 While VRST=1 at a VCLK edge, the block SHALL set FSM=WAIT_SYNC, vdata_valid_o=0, vdata_o=0, vinfo_o=2'b00 and sync_err_o=0, and clear all counters and holding registers.
REQ-025 A reset asserted mid-pixel SHALL drop that pixel with no valid pulse, and SHALL suppress any sync_err_o on the first WAIT_SYNC cycle after reset.

Verification
REQ-026 The bench SHALL apply nDSYNC=0 with D_i=0x0F, then R=0x11, G=0x22, B=0x33, and check vdata_o={4'hF,7'h11,7'h22,7'h33} with vdata_valid_o high for 1 cycle, 1 cycle after B.
REQ-027 The bench SHALL drive nDSYNC low during CAP_G and check sync_err_o pulses, no valid pulse occurs for that pixel, and the next pixel assembles correctly.
REQ-028 The bench SHALL hold nDSYNC high for 6 cycles after B and check exactly one sync_err_o pulse and no valid pulses.
REQ-029 The bench SHALL run 3 fields of 262 lines each and check vinfo_o=2'b00; it SHALL then run alternating 312/313-line fields and check vinfo_o=2'b11 after the third vsync.
REQ-030 The bench SHALL coincide hsync and vsync falls on one pixel and check that line_cnt is 0 afterwards and the next field's count is unchanged.
REQ-031 The bench SHALL assert VRST for 1 cycle between G and B and check that no valid pulse occurs, all outputs are 0, and no sync_err_o pulse occurs.
